// File: rtl/gcd_pkg.sv
// Shared types for the gcd requester: FSM states, default operand width and the queued pair.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } gcd_init_state_e;

    typedef struct packed {
        logic [GCD_WIDTH-1:0] a;
        logic [GCD_WIDTH-1:0] b;
    } gcd_pair_t;

endpackage

// File: rtl/gcd_initiator_if.sv
// Upstream operand stream, gcd core load/run port and downstream result stream.
interface gcd_initiator_if import gcd_pkg::*; #(
    parameter int WIDTH = GCD_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] core_xi;
    logic [WIDTH-1:0] core_yi;
    logic             core_go;
    logic [WIDTH-1:0] core_xo;
    logic             core_rdy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_timeout;

    modport master (
        input  in_valid, in_a, in_b, core_xo, core_rdy, out_ready,
        output in_ready, core_xi, core_yi, core_go,
        output out_valid, out_gcd, out_a, out_b, out_timeout
    );

    modport slave (
        output in_valid, in_a, in_b, core_xo, core_rdy, out_ready,
        input  in_ready, core_xi, core_yi, core_go,
        input  out_valid, out_gcd, out_a, out_b, out_timeout
    );
endinterface

// File: rtl/gcd_init_fifo.sv
// Circular queue of operand pairs with full/empty flags.
// Latency: a push is visible at the head one cycle later; head data is read combinationally.
// Backpressure: pushes while full are dropped, so the writer must gate on full.
module gcd_init_fifo import gcd_pkg::*; #(
    parameter int  DEPTH  = 4,
    parameter type pair_t = gcd_pair_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_vld,
    input  pair_t wr_dat,
    input  logic  rd_rdy,
    output pair_t rd_dat,
    output logic  full,
    output logic  empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pair_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign wr_en  = wr_vld & ~full;
    assign rd_en  = rd_rdy & ~empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_dat;
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/gcd_initiator.sv
// Queues operand pairs and sequences the gcd core load/run protocol; GCD_INIT_STATS_EN adds result counters.
// Latency: pop one cycle after push, LOAD_CYCLES of load, core run time, result one cycle after core_rdy rises.
// Backpressure: in_ready drops when the queue is full; a result is held in DONE until out_ready.
module gcd_initiator import gcd_pkg::*; #(
    parameter int WIDTH       = GCD_WIDTH,
    parameter int DEPTH       = 4,
    parameter int LOAD_CYCLES = 5,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    gcd_initiator_if.master   bus
`ifdef GCD_INIT_STATS_EN
    ,
    output logic [15:0]       stat_done,
    output logic [15:0]       stat_timeout
`endif
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(LOAD_CYCLES + 1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_pair_t;

    gcd_init_state_e state, state_nx;
    op_pair_t        push_dat;
    op_pair_t        head;
    logic            full;
    logic            empty;
    logic            pop;
    logic [LW-1:0]   load_cnt;
    logic [TW-1:0]   timer;
    logic            rdy_q;
    logic            rdy_edge;
    logic            expired;

    assign push_dat      = '{a: bus.in_a, b: bus.in_b};
    assign bus.in_ready  = ~full & ~rst;
    assign bus.core_go   = (state == RUN);
    assign bus.out_valid = (state == DONE);
    assign rdy_edge      = bus.core_rdy & ~rdy_q;
    assign expired       = (timer == TW'(TIMEOUT - 1));

    gcd_init_fifo #(
        .DEPTH  (DEPTH),
        .pair_t (op_pair_t)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (bus.in_valid),
        .wr_dat (push_dat),
        .rd_rdy (pop),
        .rd_dat (head),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop      = 1'b1;
                state_nx = LOAD;
            end
            LOAD: if (load_cnt == LW'(LOAD_CYCLES - 1)) state_nx = RUN;
            RUN:  if (rdy_edge || expired) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q           <= 1'b0;
            load_cnt        <= '0;
            timer           <= '0;
            bus.core_xi     <= '0;
            bus.core_yi     <= '0;
            bus.out_a       <= '0;
            bus.out_b       <= '0;
            bus.out_gcd     <= '0;
            bus.out_timeout <= 1'b0;
        end else begin
            // Tracked in every state so a rdy already high on RUN entry is not an edge.
            rdy_q    <= bus.core_rdy;
            load_cnt <= (state == LOAD) ? load_cnt + LW'(1) : '0;
            timer    <= (state == RUN) ? timer + TW'(1) : '0;
            if (pop) begin
                bus.core_xi <= head.a;
                bus.core_yi <= head.b;
                bus.out_a   <= head.a;
                bus.out_b   <= head.b;
            end
            if (state == RUN) begin
                if (rdy_edge) begin
                    bus.out_gcd     <= bus.core_xo;
                    bus.out_timeout <= 1'b0;
                end else if (expired) begin
                    bus.out_gcd     <= '0;
                    bus.out_timeout <= 1'b1;
                end
            end
        end
    end

`ifdef GCD_INIT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_done    <= '0;
            stat_timeout <= '0;
        end else if (state == DONE && bus.out_ready) begin
            if (bus.out_timeout) begin
                if (stat_timeout != 16'hFFFF) stat_timeout <= stat_timeout + 16'd1;
            end else begin
                if (stat_done != 16'hFFFF) stat_done <= stat_done + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_gcd_initiator.sv
// Directed bench for gcd_initiator against a subtractive gcd core model.
module tb_gcd_initiator;
    import gcd_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    bit   stall;
    logic [15:0] mx = '0;
    logic [15:0] my = '0;
    logic        mrdy = 1'b0;
`ifdef GCD_INIT_STATS_EN
    logic [15:0] stat_done;
    logic [15:0] stat_timeout;
`endif

    gcd_initiator_if #(.WIDTH(16)) bus ();

    gcd_initiator #(
        .WIDTH(16), .DEPTH(4), .LOAD_CYCLES(5), .TIMEOUT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef GCD_INIT_STATS_EN
        ,
        .stat_done    (stat_done),
        .stat_timeout (stat_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: loads while go is low, subtracts while go is high, raises rdy when x == y.
    always @(posedge clk) begin
        if (!bus.core_go) begin
            mx   <= bus.core_xi;
            my   <= bus.core_yi;
            mrdy <= 1'b0;
        end else if (!stall && !mrdy) begin
            if (mx == my)     mrdy <= 1'b1;
            else if (mx > my) mx   <= mx - my;
            else              my   <= my - mx;
        end
    end
    assign bus.core_xo  = mx;
    assign bus.core_rdy = mrdy;

    task automatic push(input logic [15:0] a, input logic [15:0] b, output int waited);
        waited = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok, output int go_n);
        ok   = 1'b0;
        go_n = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_valid)    ok = 1'b1;
            else if (bus.core_go) go_n++;
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        tests++; if ({bus.out_valid, bus.core_go, bus.out_timeout} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got valid/go/tmo=%b want 000", {bus.out_valid, bus.core_go, bus.out_timeout}); end
        tests++; if ({bus.core_xi, bus.core_yi, bus.out_gcd, bus.out_a, bus.out_b} !== 80'h0) begin
            fails++; $display("FAIL reset_data: got xi=%0d yi=%0d gcd=%0d a=%0d b=%0d want all 0", bus.core_xi, bus.core_yi, bus.out_gcd, bus.out_a, bus.out_b); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single();
        int w, n, go_n;
        bit ok;
        push(16'd13, 16'd7, w);
        @(negedge clk);
        tests++; if (bus.core_go !== 1'b0) begin fails++; $display("FAIL single_idle_go: got %b want 0", bus.core_go); end
        @(negedge clk);
        tests++; if ({bus.core_xi, bus.core_yi} !== {16'd13, 16'd7}) begin
            fails++; $display("FAIL single_core_ops: got %0d,%0d want 13,7", bus.core_xi, bus.core_yi); end
        n = 0;
        while (!bus.core_go && n < 20) begin n++; @(negedge clk); end
        tests++; if (n !== 5) begin fails++; $display("FAIL single_load_cycles: got %0d want 5", n); end
        wait_valid(ok, go_n);
        tests++; if (!ok) begin fails++; $display("FAIL single_valid_timeout: got no out_valid want out_valid"); end
        tests++; if ({bus.out_gcd, bus.out_a, bus.out_b, bus.out_timeout} !== {16'd1, 16'd13, 16'd7, 1'b0}) begin
            fails++; $display("FAIL single_result: got gcd=%0d a=%0d b=%0d tmo=%b want 1,13,7,0", bus.out_gcd, bus.out_a, bus.out_b, bus.out_timeout); end
        accept();
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [3] = '{16'd42, 16'd18, 16'd65535};
        logic [15:0] tb [3] = '{16'd18, 16'd42, 16'd65535};
        logic [15:0] tg [3] = '{16'd6,  16'd6,  16'd65535};
        int  w [3];
        int  go_n;
        bit  ok;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) push(ta[k], tb[k], w[k]);
        tests++; if (w[0] + w[1] + w[2] !== 0) begin fails++; $display("FAIL b2b_in_ready: got waits %0d/%0d/%0d want 0/0/0", w[0], w[1], w[2]); end
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok, go_n);
            tests++; if (!ok || {bus.out_gcd, bus.out_a, bus.out_b, bus.out_timeout} !== {tg[k], ta[k], tb[k], 1'b0}) begin
                fails++; $display("FAIL b2b_result%0d: got ok=%b gcd=%0d a=%0d b=%0d tmo=%b want gcd=%0d a=%0d b=%0d tmo=0",
                                  k, ok, bus.out_gcd, bus.out_a, bus.out_b, bus.out_timeout, tg[k], ta[k], tb[k]); end
            @(negedge clk);
            tests++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
                fails++; $display("FAIL b2b_pulse%0d: got valid=%b in_ready=%b want 0,1", k, bus.out_valid, bus.in_ready); end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_full_timeout();
        logic [15:0] ta [5] = '{16'd21, 16'd9, 16'd8, 16'd30, 16'd35};
        logic [15:0] tb [5] = '{16'd14, 16'd6, 16'd8, 16'd12, 16'd49};
        logic [15:0] tg [5] = '{16'd7,  16'd3, 16'd8, 16'd6,  16'd7};
        int  w, wsum, go_n, n;
        bit  ok;
        stall = 1'b1;
        bus.out_ready = 1'b0;
        push(16'd100, 16'd75, w);
        wsum = w;
        for (int k = 0; k < 4; k++) begin push(ta[k], tb[k], w); wsum += w; end
        tests++; if (wsum !== 0) begin fails++; $display("FAIL fill_waits: got %0d want 0", wsum); end
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
        bus.in_valid = 1'b1; bus.in_a = ta[4]; bus.in_b = tb[4];
        wait_valid(ok, go_n);
        tests++; if (!ok || {bus.out_gcd, bus.out_timeout, bus.out_a, bus.out_b} !== {16'd0, 1'b1, 16'd100, 16'd75}) begin
            fails++; $display("FAIL timeout_result: got ok=%b gcd=%0d tmo=%b a=%0d b=%0d want 0,1,100,75", ok, bus.out_gcd, bus.out_timeout, bus.out_a, bus.out_b); end
        tests++; if (go_n !== 16) begin fails++; $display("FAIL timeout_run_cycles: got %0d want 16", go_n); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL fifth_refused: got in_ready=%b want 0", bus.in_ready); end
        stall = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        tests++; if (n !== 2) begin fails++; $display("FAIL fifth_accept_delay: got %0d want 2", n); end
        for (int k = 0; k < 5; k++) begin
            wait_valid(ok, go_n);
            tests++; if (!ok || {bus.out_gcd, bus.out_a, bus.out_b, bus.out_timeout} !== {tg[k], ta[k], tb[k], 1'b0}) begin
                fails++; $display("FAIL after_timeout%0d: got ok=%b gcd=%0d a=%0d b=%0d tmo=%b want gcd=%0d a=%0d b=%0d tmo=0",
                                  k, ok, bus.out_gcd, bus.out_a, bus.out_b, bus.out_timeout, tg[k], ta[k], tb[k]); end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_hold();
        int w, go_n, bad;
        bit ok;
        push(16'd12, 16'd18, w);
        push(16'd50, 16'd20, w);
        wait_valid(ok, go_n);
        tests++; if (!ok || bus.out_gcd !== 16'd6) begin fails++; $display("FAIL hold_result: got ok=%b gcd=%0d want 6", ok, bus.out_gcd); end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_gcd !== 16'd6 || bus.out_a !== 16'd12 ||
                bus.out_b !== 16'd18 || bus.core_go !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
        accept();
        @(negedge clk);
        tests++; if ({bus.out_valid, bus.core_go, bus.core_xi} !== {1'b0, 1'b0, 16'd12}) begin
            fails++; $display("FAIL hold_idle_gap: got valid=%b go=%b xi=%0d want 0,0,12", bus.out_valid, bus.core_go, bus.core_xi); end
        @(negedge clk);
        tests++; if ({bus.core_go, bus.core_xi, bus.core_yi} !== {1'b0, 16'd50, 16'd20}) begin
            fails++; $display("FAIL hold_next_load: got go=%b xi=%0d yi=%0d want 0,50,20", bus.core_go, bus.core_xi, bus.core_yi); end
        wait_valid(ok, go_n);
        tests++; if (!ok || bus.out_gcd !== 16'd10) begin fails++; $display("FAIL hold_second: got ok=%b gcd=%0d want 10", ok, bus.out_gcd); end
        accept();
    endtask

    task automatic test_reset_midrun();
        int w, n, seen;
        stall = 1'b1;
        bus.out_ready = 1'b0;
        push(16'd40, 16'd30, w);
        push(16'd7, 16'd7, w);
        push(16'd3, 16'd9, w);
        n = 0;
        while (!bus.core_go && n < 50) begin @(negedge clk); n++; end
        tests++; if (bus.core_go !== 1'b1) begin fails++; $display("FAIL midrun_reach_run: got go=%b want 1", bus.core_go); end
`ifdef GCD_INIT_STATS_EN
        tests++; if ({stat_done, stat_timeout} !== {16'd11, 16'd1}) begin
            fails++; $display("FAIL stats: got done=%0d tmo=%0d want 11,1", stat_done, stat_timeout); end
`endif
        #2 rst = 1'b1;
        #1;
        tests++; if ({bus.core_go, bus.in_ready, bus.out_valid} !== 3'b000) begin
            fails++; $display("FAIL midrun_reset: got go=%b in_ready=%b valid=%b want 000", bus.core_go, bus.in_ready, bus.out_valid); end
`ifdef GCD_INIT_STATS_EN
        tests++; if ({stat_done, stat_timeout} !== 32'h0) begin
            fails++; $display("FAIL stats_reset: got done=%0d tmo=%0d want 0,0", stat_done, stat_timeout); end
`endif
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        tests++; if ({bus.in_ready, bus.core_xi} !== {1'b1, 16'd0}) begin
            fails++; $display("FAIL midrun_after: got in_ready=%b xi=%0d want 1,0", bus.in_ready, bus.core_xi); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.core_go !== 1'b0 || bus.out_valid !== 1'b0) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL midrun_discard: got %0d active cycles want 0", seen); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_timeout();
        test_hold();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
